hazard_ctrl_s: RTL and testbench
================================

Name: hazard_ctrl_s

Overview:
- Pipeline hazard controller sitting beside the ID/EX register.
- Reads the EX-side fields captured by ID/EX, plus the ID-side source registers of the next instruction. From these it drives stall, bubble and flush controls back into the PC, IF/ID and ID/EX registers.
- Handles three hazard classes: load-use hazards, taken branch/jump redirects (with a multi-cycle flush window), and data-memory wait freezes (with a watchdog).

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID stays flushed after a redirect (1..7); the first cycle also flushes ID/EX.
- MAX_STALL, 64: consecutive mem_busy cycles tolerated before stall_timeout sets (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_isValid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  5 each  ID source registers.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_isValid  in  1  EX holds a valid instruction.
- ex_rd  in  5  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_jump  in  1  EX instruction is a jump.
- ex_branch  in  1  EX instruction is a branch.
- ex_taken  in  1  EX branch condition resolved true.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the register.
- idex_bubble  out  1  load ID/EX with isValid=0.
- ifid_flush, idex_flush  out  1 each  clear register to invalid.
- redirect  out  1  PC takes the EX target this cycle.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- FSM states: RUN, LU_STALL, REDIRECT, MEM_WAIT. Reset state is RUN.
- While reset=0:
  - all outputs are 0;
  - flush counter and busy counter are 0;
  - stall_timeout is 0.
- A reset assertion mid-flush or mid-wait aborts immediately to RUN.
- Decode terms, combinational in the current cycle:
  - lu = ex_isValid & ex_mem_read & ex_rd!=0 & id_isValid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - br = ex_isValid & (ex_jump | (ex_branch & ex_taken)).
- Priority: mem_busy > br > lu. All controls are combinational from state and inputs; zero added latency.
- mem_busy=1, from any state:
  - pc_stall, ifid_stall, idex_stall and exmem_stall are all 1.
  - No flush, bubble or redirect is asserted.
  - Next state is MEM_WAIT and the busy counter increments, saturating at 255.
  - When busy counter == MAX_STALL and mem_busy=1, stall_timeout sets and stays 1 until reset.
  - The busy counter clears on the first cycle mem_busy=0.
- MEM_WAIT with mem_busy=0: evaluated exactly as RUN in the same cycle. A br or lu pending behind the freeze fires on this first unfrozen cycle.
- RUN or MEM_WAIT with br:
  - redirect, ifid_flush and idex_flush are 1.
  - If FLUSH_CYCLES>1: load flush counter with FLUSH_CYCLES-1 and go to REDIRECT; otherwise go to RUN.
- REDIRECT:
  - ifid_flush=1 each cycle; the counter decrements; go to RUN when it reaches 0.
  - A new br here is ignored, because EX holds a flushed (invalid) slot.
  - lu is ignored.
- RUN or MEM_WAIT with lu and no br:
  - pc_stall, ifid_stall and idex_bubble are 1; go to LU_STALL.
- LU_STALL (one cycle; EX now holds the bubble): evaluated as RUN.
  - A second lu against a different load is legal and re-enters LU_STALL.
- No hazard: all controls 0; state RUN.
- Register x0 never causes a load-use stall.

Optional Feature:
- HAZ_PERF_CNT_EN, when defined, adds three 32-bit outputs, wrapping at 2^32:
  - lu_stall_count: +1 per cycle idex_bubble=1.
  - flush_count: +1 per cycle redirect=1.
  - busy_count: +1 per cycle mem_busy=1.
- All three reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, both valid.
  - Response: same cycle pc_stall=ifid_stall=idex_bubble=1.
  - Then, with ex_isValid=0: all controls 0 and state RUN.
- x0 and unused sources:
  - ex_rd=0 with id_rs1=0 → no stall.
  - ex_rd=7, id_rs2=7, id_use_rs2=0 → no stall.
- Redirect with FLUSH_CYCLES=3:
  - Stimulus: ex_branch=1, ex_taken=1.
  - Response, cycle 0: redirect=ifid_flush=idex_flush=1. Cycles 1-2: ifid_flush only. Cycle 3: RUN.
- Priority:
  - Stimulus: lu and br true together.
  - Response: redirect/flush asserted, idex_bubble=0.
  - Then mem_busy=1 with br: only the four stalls; redirect fires the cycle after mem_busy drops.
- Watchdog with MAX_STALL=4:
  - 3 busy cycles → stall_timeout=0.
  - A continuous run of busy cycles → stall_timeout=1 from the cycle the busy counter reaches 4, and it stays 1 after mem_busy drops.
  - Async reset mid-run clears it without a clock edge.
- With HAZ_PERF_CNT_EN:
  - Stimulus: 2 lu events, 1 redirect, 5 busy cycles.
  - Response: counters read 2/1/5.

Source files
------------

// File: rtl/hazard_ctrl_s.sv
// Hazard controller beside ID/EX: load-use stalls, branch/jump flush windows and memory-wait freezes.
// Optional HAZ_PERF_CNT_EN adds free-running event counters (lu_stall_count, flush_count, busy_count).
module hazard_ctrl_s #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_isValid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_isValid,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_jump,
    input  logic       ex_branch,
    input  logic       ex_taken,
    input  logic       mem_busy,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       redirect,
    output logic       stall_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] busy_count
`endif
);

    typedef enum logic [1:0] {RUN, LU_STALL, REDIRECT, MEM_WAIT} state_t;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MAX_STALL_B = 8'(MAX_STALL);

    state_t     state_reg, state_next;
    logic [2:0] flush_cnt_reg, flush_cnt_next;
    logic [7:0] busy_cnt_reg, busy_cnt_next;
    logic       timeout_reg;

    logic lu, br, timeout_hit;
    logic pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c;
    logic idex_bubble_c, ifid_flush_c, idex_flush_c, redirect_c;

    assign lu = ex_isValid & ex_mem_read & (ex_rd != 5'd0) & id_isValid &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign br = ex_isValid & (ex_jump | (ex_branch & ex_taken));

    // Visible in the same cycle the counter sits at the limit while memory is still busy.
    assign timeout_hit = mem_busy & (busy_cnt_reg == MAX_STALL_B);

    always_comb begin
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        idex_stall_c   = 1'b0;
        exmem_stall_c  = 1'b0;
        idex_bubble_c  = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        redirect_c     = 1'b0;
        state_next     = RUN;
        flush_cnt_next = flush_cnt_reg;
        busy_cnt_next  = 8'd0;

        if (mem_busy) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            state_next    = MEM_WAIT;
            busy_cnt_next = (busy_cnt_reg == 8'hFF) ? busy_cnt_reg : busy_cnt_reg + 8'd1;
        end else if (state_reg == REDIRECT) begin
            // EX holds a flushed slot here, so br and lu are both don't-care.
            ifid_flush_c   = 1'b1;
            flush_cnt_next = (flush_cnt_reg == 3'd0) ? 3'd0 : flush_cnt_reg - 3'd1;
            state_next     = (flush_cnt_reg <= 3'd1) ? RUN : REDIRECT;
        end else if (br) begin
            redirect_c   = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                flush_cnt_next = FLUSH_LOAD;
                state_next     = REDIRECT;
            end
        end else if (lu) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_next    = LU_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 3'd0;
            busy_cnt_reg  <= 8'd0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            busy_cnt_reg  <= busy_cnt_next;
            timeout_reg   <= timeout_reg | timeout_hit;
        end
    end

    // Controls are combinational, so they are forced low while reset is held.
    assign pc_stall      = reset & pc_stall_c;
    assign ifid_stall    = reset & ifid_stall_c;
    assign idex_stall    = reset & idex_stall_c;
    assign exmem_stall   = reset & exmem_stall_c;
    assign idex_bubble   = reset & idex_bubble_c;
    assign ifid_flush    = reset & ifid_flush_c;
    assign idex_flush    = reset & idex_flush_c;
    assign redirect      = reset & redirect_c;
    assign stall_timeout = reset & (timeout_reg | timeout_hit);

`ifdef HAZ_PERF_CNT_EN
    logic [2:0]  perf_inc;
    logic [31:0] perf_reg [3];

    assign perf_inc = {mem_busy, redirect, idex_bubble};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    perf_reg[gi] <= 32'd0;
                end else if (perf_inc[gi]) begin
                    perf_reg[gi] <= perf_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign lu_stall_count = perf_reg[0];
    assign flush_count    = perf_reg[1];
    assign busy_count     = perf_reg[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl_s.sv
// Directed bench for hazard_ctrl_s (FLUSH_CYCLES=3, MAX_STALL=4) with an expected-value queue.
module tb_hazard_ctrl_s;

    logic       clk;
    logic       reset;
    logic       id_isValid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_isValid;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_jump;
    logic       ex_branch;
    logic       ex_taken;
    logic       mem_busy;
    logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       idex_bubble, ifid_flush, idex_flush, redirect, stall_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] lu_stall_count, flush_count, busy_count;
`endif

    hazard_ctrl_s #(.FLUSH_CYCLES(3), .MAX_STALL(4)) dut (
        .clk(clk), .reset(reset),
        .id_isValid(id_isValid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_isValid(ex_isValid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .mem_busy(mem_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .redirect(redirect), .stall_timeout(stall_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .lu_stall_count(lu_stall_count), .flush_count(flush_count), .busy_count(busy_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush, idex_flush, redirect, stall_timeout}
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_LU   = 9'b110010000;
    localparam logic [8:0] E_BR   = 9'b000001110;
    localparam logic [8:0] E_FL   = 9'b000001000;
    localparam logic [8:0] E_BUSY = 9'b111100000;
    localparam logic [8:0] E_TO   = 9'b000000001;

    typedef struct {
        logic [8:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic logic [8:0] outs();
        return {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
                ifid_flush, idex_flush, redirect, stall_timeout};
    endfunction

    task automatic idle();
        id_isValid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_isValid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0;
        ex_jump = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        ex_isValid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
        id_isValid = 1'b1; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    endtask

    task automatic set_br();
        ex_isValid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
    endtask

    // Inputs were just driven after a falling edge; record the expectation, let
    // the logic settle, then compare well before the next rising edge.
    task automatic chk(input logic [8:0] exp, input string tag);
        sb_t e;
        logic [8:0] got;
        sb_q.push_back('{exp: exp, tag: tag});
        #2;
        got = outs();
        total++;
        assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            assert (got === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", e.tag, got, e.exp);
            end
            $display("step %-12s outs=%b exp=%b", e.tag, got, e.exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        mem_busy = 1'b1;
        #1;
        chk(E_NONE, "reset_outs");
        @(negedge clk); reset = 1'b1; idle();

        // Load-use detection and recovery.
        step(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); chk(E_LU, "lu_rs1");
        step(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); ex_isValid = 1'b0; chk(E_NONE, "lu_after");
        step(); set_lu(5'd9, 5'd0, 1'b0, 5'd9, 1'b1); chk(E_LU, "lu_rs2");
        step(); set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); chk(E_LU, "lu_reenter");
        step(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); chk(E_NONE, "lu_x0");
        step(); set_lu(5'd7, 5'd0, 1'b0, 5'd7, 1'b0); chk(E_NONE, "lu_unused");
        step(); set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); id_isValid = 1'b0; chk(E_NONE, "lu_id_inv");
        step(); set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); ex_mem_read = 1'b0; chk(E_NONE, "lu_noload");

        // Taken branch with a three-cycle flush window; hazards inside it are ignored.
        step(); set_br(); chk(E_BR, "br_c0");
        step(); set_br(); set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); chk(E_FL, "br_c1");
        step(); chk(E_FL, "br_c2");
        step(); chk(E_NONE, "br_c3");
        step(); ex_isValid = 1'b1; ex_branch = 1'b1; chk(E_NONE, "br_ntaken");
        step(); ex_jump = 1'b1; chk(E_NONE, "jmp_inv");
        step(); ex_isValid = 1'b1; ex_jump = 1'b1; chk(E_BR, "jmp_c0");
        step(); chk(E_FL, "jmp_c1");
        step(); chk(E_FL, "jmp_c2");

        // Priority: branch over load-use, then memory freeze over branch.
        step(); set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); set_br(); chk(E_BR, "pri_br_lu");
        step(); chk(E_FL, "pri_c1");
        step(); chk(E_FL, "pri_c2");
        step(); set_br(); mem_busy = 1'b1; chk(E_BUSY, "pri_busy");
        step(); set_br(); chk(E_BR, "pri_release");
        step(); chk(E_FL, "pri_rel_c1");
        step(); chk(E_FL, "pri_rel_c2");
        step(); chk(E_NONE, "pri_rel_c3");
        step(); set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); mem_busy = 1'b1; chk(E_BUSY, "busy_lu");
        step(); set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); chk(E_LU, "lu_after_busy");

        // Watchdog: a short burst stays clear, a long one latches the flag.
        for (int i = 0; i < 3; i++) begin
            step(); mem_busy = 1'b1; chk(E_BUSY, $sformatf("wd_short%0d", i));
        end
        step(); chk(E_NONE, "wd_short_end");
        for (int i = 0; i < 4; i++) begin
            step(); mem_busy = 1'b1; chk(E_BUSY, $sformatf("wd_long%0d", i));
        end
        step(); mem_busy = 1'b1; chk(E_BUSY | E_TO, "wd_hit");
        step(); mem_busy = 1'b1; chk(E_BUSY | E_TO, "wd_hold");
        step(); chk(E_TO, "wd_sticky");
        step(); set_br(); chk(E_BR | E_TO, "wd_sticky_br");

        // Asynchronous reset with no intervening clock edge, mid-flush.
        step(); mem_busy = 1'b1; reset = 1'b0; chk(E_NONE, "async_rst");
        step(); reset = 1'b1; chk(E_NONE, "rst_release");
        step(); set_br(); chk(E_BR, "abort_br");
        step(); reset = 1'b0; chk(E_NONE, "abort_rst");
        step(); reset = 1'b1; chk(E_NONE, "abort_run");

`ifdef HAZ_PERF_CNT_EN
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        step(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); chk(E_LU, "perf_lu0");
        step(); set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); chk(E_LU, "perf_lu1");
        step(); set_br(); chk(E_BR, "perf_br");
        step(); chk(E_FL, "perf_fl1");
        step(); chk(E_FL, "perf_fl2");
        for (int i = 0; i < 5; i++) begin
            step(); mem_busy = 1'b1; chk(E_BUSY, $sformatf("perf_busy%0d", i));
        end
        step();
        #2;
        total++;
        assert (lu_stall_count === 32'd2) else begin
            bad++; $error("FAIL perf_lu observed=%0d expected=2", lu_stall_count);
        end
        total++;
        assert (flush_count === 32'd1) else begin
            bad++; $error("FAIL perf_flush observed=%0d expected=1", flush_count);
        end
        total++;
        assert (busy_count === 32'd5) else begin
            bad++; $error("FAIL perf_busy observed=%0d expected=5", busy_count);
        end
        $display("perf lu=%0d flush=%0d busy=%0d", lu_stall_count, flush_count, busy_count);
`endif

        total++;
        assert (sb_q.size() == 0) else begin
            bad++; $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
